// File: rtl/c2f_writer_if.sv
// c2f_writer_if: CPU->FPGA TLP receive stream plus the RAM write port of the C2F writer
interface c2f_writer_if #(
  parameter int IDX_W = 3,
  parameter int OFF_W = 4
);
  logic [63:0]      rxData;
  logic             rxValid;
  logic             rxSOP;
  logic             rxEOP;
  logic             rxReady;
  logic             wrEnable;
  logic [7:0]       wrByteMask;
  logic [IDX_W-1:0] wrPtrIndex;
  logic [OFF_W-1:0] wrOffset;
  logic [63:0]      wrData;
  modport master (
    output rxData, rxValid, rxSOP, rxEOP,
    input  rxReady, wrEnable, wrByteMask, wrPtrIndex, wrOffset, wrData
  );
  modport slave (
    input  rxData, rxValid, rxSOP, rxEOP,
    output rxReady, wrEnable, wrByteMask, wrPtrIndex, wrOffset, wrData
  );
endinterface

// File: rtl/c2f_writer.sv
// c2f_writer: decodes MWr TLPs into chunked RAM writes and commits full chunks; dropCount port under `ifdef C2F_DROP_COUNT_EN
module c2f_writer #(
  parameter int CHUNK_BYTES = 128,
  parameter int N_CHUNKS    = 8,
  localparam int IDX_W = $clog2(N_CHUNKS),
  localparam int OFF_W = $clog2(CHUNK_BYTES / 8),
  localparam int PTR_W = IDX_W + OFF_W
) (
  input  logic             sysClk,
  input  logic             sysRst_n,
  c2f_writer_if.slave      rx,
  input  logic [IDX_W-1:0] rdIndex,
  output logic [IDX_W-1:0] wrIndex,
  output logic             c2fFull
`ifdef C2F_DROP_COUNT_EN
  ,
  output logic [31:0]      dropCount
`endif
);
  typedef enum logic [1:0] {IDLE, HDR2, DATA, DISCARD} state_t;
  state_t           state_q, state_d;
  logic [9:0]       len_q, len_d, rem_q, rem_d;
  logic [3:0]       fbe_q, fbe_d, lbe_q, lbe_d;
  logic             is4_q, is4_d, first_q, first_d, rdy_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [7:0]       mask_q, mask_d;
  logic [IDX_W-1:0] wptr_q, wptr_d, wri_q, wri_d, idx;
  logic [OFF_W-1:0] woff_q, woff_d, off;
  logic [63:0]      wdat_q, wdat_d;
  logic [PTR_W+2:0] addr_lo;
  logic [7:0]       fmt;
  logic             beat, is_mwr, drop, commit;
`ifdef C2F_DROP_COUNT_EN
  logic [31:0]      dcnt_q, dcnt_d;
  assign dropCount = dcnt_q;
`endif
  assign beat    = rx.rxValid & rdy_q;
  assign fmt     = rx.rxData[31:24];
  assign is_mwr  = fmt == 8'h40 || fmt == 8'h60;
  assign addr_lo = is4_q ? rx.rxData[PTR_W+34:32] : rx.rxData[PTR_W+2:0];
  assign idx     = ptr_q[PTR_W-1:OFF_W];
  assign off     = ptr_q[OFF_W-1:0];
  assign c2fFull = wri_q + IDX_W'(1) == rdIndex;
  // a chunk is committed but unread, or it is the open chunk while the ring is full
  assign drop    = (idx - rdIndex < wri_q - rdIndex) || (idx == wri_q && c2fFull);
  // commit is taken from the registered write so it lands one cycle after the RAM write
  assign commit  = we_q && (&woff_q) && wptr_q == wri_q;
  assign wrIndex        = wri_q;
  assign rx.rxReady     = rdy_q;
  assign rx.wrEnable    = we_q;
  assign rx.wrByteMask  = mask_q;
  assign rx.wrPtrIndex  = wptr_q;
  assign rx.wrOffset    = woff_q;
  assign rx.wrData      = wdat_q;
  // next state: TLP decode, address tracking, RAM write generation and commit
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    fbe_d   = fbe_q;
    lbe_d   = lbe_q;
    is4_d   = is4_q;
    first_d = first_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    mask_d  = mask_q;
    wptr_d  = wptr_q;
    woff_d  = woff_q;
    wdat_d  = wdat_q;
    wri_d   = commit ? wri_q + IDX_W'(1) : wri_q;
`ifdef C2F_DROP_COUNT_EN
    dcnt_d  = dcnt_q;
`endif
    if (beat) begin
      if (state_q == IDLE || (rx.rxSOP && (state_q == DATA || state_q == DISCARD))) begin
        if (rx.rxSOP) begin
          state_d = rx.rxEOP ? IDLE : is_mwr ? HDR2 : DISCARD;
          len_d   = rx.rxData[9:0];
          fbe_d   = rx.rxData[35:32];
          lbe_d   = rx.rxData[39:36];
          is4_d   = fmt == 8'h60;
        end
      end else if (state_q == HDR2) begin
        state_d = rx.rxEOP ? IDLE : (addr_lo[2:0] != 3'd0 || len_q[0]) ? DISCARD : DATA;
        ptr_d   = addr_lo[PTR_W+2:3];
        rem_d   = {len_q == 10'd0, len_q[9:1]};
        first_d = 1'b1;
      end else if (state_q == DATA) begin
        state_d = rx.rxEOP ? IDLE : DATA;
        we_d    = !drop;
        mask_d  = len_q == 10'd2 ? {lbe_q, fbe_q} : first_q ? {4'hF, fbe_q} :
                  rem_q == 10'd1 ? {lbe_q, 4'hF} : 8'hFF;
        wptr_d  = idx;
        woff_d  = off;
        wdat_d  = rx.rxData;
        ptr_d   = ptr_q + PTR_W'(1);
        rem_d   = rem_q - 10'd1;
        first_d = 1'b0;
`ifdef C2F_DROP_COUNT_EN
        dcnt_d  = (drop && !(&dcnt_q)) ? dcnt_q + 32'd1 : dcnt_q;
`endif
      end else begin
        state_d = rx.rxEOP ? IDLE : DISCARD;
      end
    end
  end
  // state registers; reset abandons any TLP in flight and holds off rxReady for one edge
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      fbe_q   <= '0;
      lbe_q   <= '0;
      is4_q   <= 1'b0;
      first_q <= 1'b0;
      ptr_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wptr_q  <= '0;
      woff_q  <= '0;
      wdat_q  <= '0;
      wri_q   <= '0;
`ifdef C2F_DROP_COUNT_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      fbe_q   <= fbe_d;
      lbe_q   <= lbe_d;
      is4_q   <= is4_d;
      first_q <= first_d;
      ptr_q   <= ptr_d;
      rdy_q   <= 1'b1;
      we_q    <= we_d;
      mask_q  <= mask_d;
      wptr_q  <= wptr_d;
      woff_q  <= woff_d;
      wdat_q  <= wdat_d;
      wri_q   <= wri_d;
`ifdef C2F_DROP_COUNT_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_c2f_writer.sv
// tb_c2f_writer: directed bench for c2f_writer with 128-byte chunks and 8 chunks
module tb_c2f_writer;
  logic       sysClk = 1'b0;
  logic       sysRst_n = 1'b1;
  logic [2:0] rdIndex = 3'd0;
  logic [2:0] wrIndex;
  logic       c2fFull;
  int         asserts = 0;
  int         fails = 0;
  int         nwr = 0;
  int         base;
`ifdef C2F_DROP_COUNT_EN
  logic [31:0] dropCount;
`endif
  c2f_writer_if bus ();
  c2f_writer dut (
    .sysClk   (sysClk),
    .sysRst_n (sysRst_n),
    .rx       (bus),
    .rdIndex  (rdIndex),
    .wrIndex  (wrIndex),
    .c2fFull  (c2fFull)
`ifdef C2F_DROP_COUNT_EN
    ,
    .dropCount(dropCount)
`endif
  );
  always #5 sysClk = ~sysClk;
  always @(negedge sysClk) if (bus.wrEnable === 1'b1) nwr++;
  function automatic logic [63:0] seq(input int i);
    return {32'hC0DE0000 + 32'(i), 32'hDA7A0000 + 32'(i)};
  endfunction
  task automatic beat(input logic [63:0] d, input logic sop, input logic eop);
    bus.rxData  = d;
    bus.rxValid = 1'b1;
    bus.rxSOP   = sop;
    bus.rxEOP   = eop;
    @(posedge sysClk);
    #1;
    bus.rxValid = 1'b0;
    bus.rxSOP   = 1'b0;
    bus.rxEOP   = 1'b0;
  endtask
  task automatic hdr(input logic [7:0] fmt, input logic [9:0] len, input logic [3:0] fbe,
                     input logic [3:0] lbe, input logic [31:0] addr);
    beat({24'h0, lbe, fbe, fmt, 14'h0, len}, 1'b1, 1'b0);
    beat(fmt == 8'h60 ? {addr, 32'h0} : {32'h0, addr}, 1'b0, 1'b0);
  endtask
  task automatic write_chunk(input int c);
    hdr(8'h60, 10'd32, 4'hF, 4'hF, 32'(c * 128));
    for (int i = 0; i < 16; i++) beat(seq(c * 16 + i), 1'b0, i == 15);
    @(posedge sysClk);
    #1;
  endtask
  task automatic do_reset;
    rdIndex  = 3'd0;
    sysRst_n = 1'b0;
    #2;
    @(negedge sysClk);
    sysRst_n = 1'b1;
    @(posedge sysClk);
    #1;
  endtask
  task automatic test_reset;
    #1;
    sysRst_n = 1'b0;
    #2;
    asserts++; if (bus.rxReady !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", bus.rxReady); end
    asserts++; if (bus.wrEnable !== 1'b0) begin fails++; $display("FAIL rst_we got %b want 0", bus.wrEnable); end
    asserts++; if (wrIndex !== 3'd0) begin fails++; $display("FAIL rst_wridx got %0d want 0", wrIndex); end
    asserts++; if (c2fFull !== 1'b0) begin fails++; $display("FAIL rst_full got %b want 0", c2fFull); end
`ifdef C2F_DROP_COUNT_EN
    asserts++; if (dropCount !== 32'd0) begin fails++; $display("FAIL rst_drops got %0d want 0", dropCount); end
`endif
    @(negedge sysClk);
    sysRst_n = 1'b1;
    @(posedge sysClk);
    #1;
    asserts++; if (bus.rxReady !== 1'b1) begin fails++; $display("FAIL rst_ready_rise got %b want 1", bus.rxReady); end
  endtask
  task automatic test_short;
    do_reset;
    base = nwr;
    hdr(8'h40, 10'd2, 4'h3, 4'hC, 32'h8);
    beat(64'h1122334455667788, 1'b0, 1'b1);
    asserts++; if (bus.wrEnable !== 1'b1) begin fails++; $display("FAIL short_we got %b want 1", bus.wrEnable); end
    asserts++; if (bus.wrOffset !== 4'd1) begin fails++; $display("FAIL short_off got %0d want 1", bus.wrOffset); end
    asserts++; if (bus.wrPtrIndex !== 3'd0) begin fails++; $display("FAIL short_idx got %0d want 0", bus.wrPtrIndex); end
    asserts++; if (bus.wrByteMask !== 8'hC3) begin fails++; $display("FAIL short_mask got %h want c3", bus.wrByteMask); end
    asserts++; if (bus.wrData !== 64'h1122334455667788) begin fails++; $display("FAIL short_data got %h want 1122334455667788", bus.wrData); end
    @(posedge sysClk);
    #1;
    asserts++; if (bus.wrEnable !== 1'b0) begin fails++; $display("FAIL short_we_off got %b want 0", bus.wrEnable); end
    asserts++; if (wrIndex !== 3'd0) begin fails++; $display("FAIL short_nocommit got %0d want 0", wrIndex); end
    asserts++; if (nwr - base !== 1) begin fails++; $display("FAIL short_count got %0d want 1", nwr - base); end
  endtask
  task automatic test_mask;
    do_reset;
    hdr(8'h40, 10'd6, 4'h1, 4'h8, 32'h10);
    beat(seq(40), 1'b0, 1'b0);
    asserts++; if (bus.wrByteMask !== 8'hF1 || bus.wrOffset !== 4'd2) begin fails++; $display("FAIL mask_first got %h/%0d want f1/2", bus.wrByteMask, bus.wrOffset); end
    beat(seq(41), 1'b0, 1'b0);
    asserts++; if (bus.wrByteMask !== 8'hFF || bus.wrOffset !== 4'd3) begin fails++; $display("FAIL mask_mid got %h/%0d want ff/3", bus.wrByteMask, bus.wrOffset); end
    beat(seq(42), 1'b0, 1'b1);
    asserts++; if (bus.wrByteMask !== 8'h8F || bus.wrOffset !== 4'd4) begin fails++; $display("FAIL mask_last got %h/%0d want 8f/4", bus.wrByteMask, bus.wrOffset); end
  endtask
  task automatic test_full_chunk;
    do_reset;
    base = nwr;
    hdr(8'h60, 10'd32, 4'hF, 4'hF, 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        repeat (3) @(posedge sysClk);
        #1;
        asserts++; if (bus.wrEnable !== 1'b0) begin fails++; $display("FAIL chunk_gap_we got %b want 0", bus.wrEnable); end
      end
      beat(seq(i), 1'b0, i == 15);
      asserts++; if (bus.wrEnable !== 1'b1) begin fails++; $display("FAIL chunk_we[%0d] got %b want 1", i, bus.wrEnable); end
      asserts++; if (bus.wrOffset !== 4'(i)) begin fails++; $display("FAIL chunk_off[%0d] got %0d want %0d", i, bus.wrOffset, i); end
      asserts++; if (bus.wrByteMask !== 8'hFF) begin fails++; $display("FAIL chunk_mask[%0d] got %h want ff", i, bus.wrByteMask); end
      asserts++; if (bus.wrData !== seq(i)) begin fails++; $display("FAIL chunk_data[%0d] got %h want %h", i, bus.wrData, seq(i)); end
      asserts++; if (wrIndex !== 3'd0) begin fails++; $display("FAIL chunk_wridx[%0d] got %0d want 0", i, wrIndex); end
    end
    @(posedge sysClk);
    #1;
    asserts++; if (wrIndex !== 3'd1) begin fails++; $display("FAIL chunk_commit got %0d want 1", wrIndex); end
    asserts++; if (bus.wrEnable !== 1'b0) begin fails++; $display("FAIL chunk_we_end got %b want 0", bus.wrEnable); end
    asserts++; if (nwr - base !== 16) begin fails++; $display("FAIL chunk_count got %0d want 16", nwr - base); end
  endtask
  task automatic test_back_to_back;
    do_reset;
    base = nwr;
    hdr(8'h60, 10'd32, 4'hF, 4'hF, 32'h0);
    beat(seq(0), 1'b0, 1'b0);
    beat(seq(1), 1'b0, 1'b0);
    hdr(8'h40, 10'd2, 4'h3, 4'hC, 32'h18);
    beat(64'hABCD, 1'b0, 1'b1);
    asserts++; if (bus.wrEnable !== 1'b1 || bus.wrOffset !== 4'd3) begin fails++; $display("FAIL b2b_off got %b/%0d want 1/3", bus.wrEnable, bus.wrOffset); end
    asserts++; if (bus.wrByteMask !== 8'hC3) begin fails++; $display("FAIL b2b_mask got %h want c3", bus.wrByteMask); end
    @(posedge sysClk);
    #1;
    asserts++; if (nwr - base !== 3) begin fails++; $display("FAIL b2b_count got %0d want 3", nwr - base); end
  endtask
  task automatic test_full_drop;
    do_reset;
    for (int c = 0; c < 7; c++) write_chunk(c);
    asserts++; if (wrIndex !== 3'd7) begin fails++; $display("FAIL full_wridx got %0d want 7", wrIndex); end
    asserts++; if (c2fFull !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", c2fFull); end
    base = nwr;
    write_chunk(7);
    asserts++; if (nwr - base !== 0) begin fails++; $display("FAIL full_drop_count got %0d want 0", nwr - base); end
    asserts++; if (wrIndex !== 3'd7) begin fails++; $display("FAIL full_hold got %0d want 7", wrIndex); end
`ifdef C2F_DROP_COUNT_EN
    asserts++; if (dropCount !== 32'd16) begin fails++; $display("FAIL full_drops got %0d want 16", dropCount); end
`endif
    base = nwr;
    hdr(8'h40, 10'd2, 4'hF, 4'hF, 32'h100);
    beat(64'hBAD, 1'b0, 1'b1);
    @(posedge sysClk);
    #1;
    asserts++; if (nwr - base !== 0) begin fails++; $display("FAIL unread_drop got %0d want 0", nwr - base); end
`ifdef C2F_DROP_COUNT_EN
    asserts++; if (dropCount !== 32'd17) begin fails++; $display("FAIL unread_drops got %0d want 17", dropCount); end
`endif
    rdIndex = 3'd3;
    #1;
    asserts++; if (c2fFull !== 1'b0) begin fails++; $display("FAIL consumed_full got %b want 0", c2fFull); end
    hdr(8'h40, 10'd2, 4'hF, 4'hF, 32'h100);
    beat(64'hFEED, 1'b0, 1'b1);
    asserts++; if (bus.wrEnable !== 1'b1) begin fails++; $display("FAIL consumed_we got %b want 1", bus.wrEnable); end
    asserts++; if (bus.wrPtrIndex !== 3'd2 || bus.wrOffset !== 4'd0) begin fails++; $display("FAIL consumed_addr got %0d/%0d want 2/0", bus.wrPtrIndex, bus.wrOffset); end
    asserts++; if (bus.wrData !== 64'hFEED) begin fails++; $display("FAIL consumed_data got %h want feed", bus.wrData); end
  endtask
  task automatic test_discard;
    do_reset;
    base = nwr;
    beat({32'h0, 32'h00000002}, 1'b1, 1'b0);
    asserts++; if (bus.rxReady !== 1'b1) begin fails++; $display("FAIL mrd_ready got %b want 1", bus.rxReady); end
    beat({32'h0, 32'h1000}, 1'b0, 1'b1);
    hdr(8'h40, 10'd2, 4'hF, 4'hF, 32'h4);
    beat(seq(0), 1'b0, 1'b1);
    asserts++; if (bus.rxReady !== 1'b1) begin fails++; $display("FAIL misalign_ready got %b want 1", bus.rxReady); end
    hdr(8'h60, 10'd3, 4'hF, 4'hF, 32'h0);
    beat(seq(1), 1'b0, 1'b0);
    beat(seq(2), 1'b0, 1'b1);
    @(posedge sysClk);
    #1;
    asserts++; if (nwr - base !== 0) begin fails++; $display("FAIL discard_count got %0d want 0", nwr - base); end
    hdr(8'h40, 10'd2, 4'hF, 4'hF, 32'h8);
    beat(seq(3), 1'b0, 1'b1);
    asserts++; if (bus.wrEnable !== 1'b1 || bus.wrOffset !== 4'd1) begin fails++; $display("FAIL discard_recover got %b/%0d want 1/1", bus.wrEnable, bus.wrOffset); end
  endtask
  task automatic test_reset_mid;
    do_reset;
    hdr(8'h60, 10'd32, 4'hF, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) beat(seq(i), 1'b0, 1'b0);
    asserts++; if (bus.wrEnable !== 1'b1) begin fails++; $display("FAIL mid_we_before got %b want 1", bus.wrEnable); end
    sysRst_n = 1'b0;
    #1;
    asserts++; if (bus.wrEnable !== 1'b0) begin fails++; $display("FAIL mid_we_drop got %b want 0", bus.wrEnable); end
    asserts++; if (wrIndex !== 3'd0) begin fails++; $display("FAIL mid_wridx got %0d want 0", wrIndex); end
    asserts++; if (bus.rxReady !== 1'b0) begin fails++; $display("FAIL mid_ready got %b want 0", bus.rxReady); end
    @(negedge sysClk);
    sysRst_n = 1'b1;
    @(posedge sysClk);
    #1;
    base = nwr;
    beat(seq(5), 1'b0, 1'b0);
    beat(seq(6), 1'b0, 1'b1);
    @(posedge sysClk);
    #1;
    asserts++; if (nwr - base !== 0) begin fails++; $display("FAIL mid_abandon got %0d want 0", nwr - base); end
    hdr(8'h40, 10'd2, 4'h3, 4'hC, 32'h8);
    beat(64'h55AA, 1'b0, 1'b1);
    asserts++; if (bus.wrEnable !== 1'b1 || bus.wrOffset !== 4'd1) begin fails++; $display("FAIL mid_next got %b/%0d want 1/1", bus.wrEnable, bus.wrOffset); end
    asserts++; if (bus.wrByteMask !== 8'hC3) begin fails++; $display("FAIL mid_next_mask got %h want c3", bus.wrByteMask); end
  endtask
  initial begin
    bus.rxData  = 64'h0;
    bus.rxValid = 1'b0;
    bus.rxSOP   = 1'b0;
    bus.rxEOP   = 1'b0;
    test_reset;
    test_short;
    test_mask;
    test_full_chunk;
    test_back_to_back;
    test_full_drop;
    test_discard;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
